mem_line_model: RTL and testbench

// Parametrised main-memory slave on the shared C2 bus (cmd/data inout, addr in); next generation of the fixed-size

---
 rtl/mem_line_model.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_line_model.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_model.sv
// mem_line_model: line-granular main-memory slave on the shared C2 bus.
// Whole-line reads and writes are split into BUS_BYTES-wide beats, low bytes first,
// with separate read/write response latencies, wrapped line addressing, completed
// transaction counters and a sticky protocol-error flag.
module mem_line_model #(
  parameter int unsigned MEM_LINES  = 64,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned BUS_BYTES  = 2,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned RD_LATENCY = 100,
  parameter int unsigned WR_LATENCY = 100,
  parameter int unsigned INIT_MODE  = 0,
  parameter logic [31:0] SEED       = 32'd225
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   m_dump,
  input  logic [ADDR_W-1:0]      addr,
  inout  logic [BUS_BYTES*8-1:0] data,
  inout  logic [1:0]             cmd,
  output logic [31:0]            n_reads,
  output logic [31:0]            n_writes,
  output logic                   proto_err
);

  localparam logic [1:0] C2_NOP        = 2'd0;
  localparam logic [1:0] C2_READ_LINE  = 2'd1;
  localparam logic [1:0] C2_WRITE_LINE = 2'd2;
  localparam logic [1:0] C2_RESPONSE   = 2'd3;

  localparam int unsigned LINE_W = LINE_BYTES * 8;
  localparam int unsigned BUS_W  = BUS_BYTES * 8;
  localparam int unsigned BEATS  = LINE_BYTES / BUS_BYTES;
  localparam int unsigned IDX_W  = $clog2(MEM_LINES);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_SEND,
    S_WR_RECV,
    S_WR_WAIT,
    S_WR_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    line_q, line_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [LINE_W-1:0]   wbuf_q, wbuf_d;
  logic [31:0]         n_reads_q, n_reads_d;
  logic [31:0]         n_writes_q, n_writes_d;
  logic                perr_q, perr_d;
  logic [LINE_W-1:0]   mem_q [MEM_LINES];

  logic [LINE_W-1:0]   init_img [MEM_LINES];
  logic [IDX_W-1:0]    addr_idx;
  logic [LINE_W-1:0]   wline;
  logic                commit_en;
  logic [IDX_W-1:0]    commit_idx;
  logic [LINE_W-1:0]   commit_line;
  logic                drive_cmd;
  logic                drive_data;
  logic [LINE_W-1:0]   rd_line;
  logic [BUS_W-1:0]    beat_out;

  // m_dump and the upper address bits deliberately have no effect on the model
  logic unused_inputs;
  assign unused_inputs = ^{m_dump, addr};

  assign addr_idx = addr[IDX_W-1:0];

  // Power-on / reset image: zeros, or bytes drawn from a Galois LFSR (x^32+x^22+x^2+x+1), 8 shifts per byte
  always_comb begin : init_gen
    logic [31:0] lfsr;
    lfsr = SEED;
    for (int unsigned l = 0; l < MEM_LINES; l++) begin
      init_img[l] = '0;
      for (int unsigned b = 0; b < LINE_BYTES; b++) begin
        if (INIT_MODE == 1) begin
          init_img[l][b*8 +: 8] = lfsr[7:0];
        end
        for (int unsigned s = 0; s < 8; s++) begin
          lfsr = lfsr[0] ? ((lfsr >> 1) ^ 32'h8020_0003) : (lfsr >> 1);
        end
      end
    end
  end

  // State register, datapath registers and line storage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      line_q     <= '0;
      beat_q     <= '0;
      cnt_q      <= '0;
      wbuf_q     <= '0;
      n_reads_q  <= '0;
      n_writes_q <= '0;
      perr_q     <= 1'b0;
      for (int unsigned i = 0; i < MEM_LINES; i++) begin
        mem_q[i] <= init_img[i];
      end
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      wbuf_q     <= wbuf_d;
      n_reads_q  <= n_reads_d;
      n_writes_q <= n_writes_d;
      perr_q     <= perr_d;
      if (commit_en) begin
        mem_q[commit_idx] <= commit_line;
      end
    end
  end

  // Next-state and datapath update; the write buffer merges the current beat into its slot
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    beat_d      = beat_q;
    cnt_d       = cnt_q;
    wbuf_d      = wbuf_q;
    n_reads_d   = n_reads_q;
    n_writes_d  = n_writes_q;
    perr_d      = perr_q;
    commit_en   = 1'b0;
    commit_idx  = line_q;
    wline       = wbuf_q;
    wline[beat_q*BUS_W +: BUS_W] = data;
    commit_line = wline;

    unique case (state_q)
      S_IDLE: begin
        if (cmd == C2_READ_LINE) begin
          line_d  = addr_idx;
          cnt_d   = 32'(RD_LATENCY - 1);
          state_d = S_RD_WAIT;
        end else if (cmd == C2_WRITE_LINE) begin
          line_d = addr_idx;
          wbuf_d = wline;
          if (BEATS == 1) begin
            commit_en  = 1'b1;
            commit_idx = addr_idx;
            cnt_d      = 32'(WR_LATENCY - 1);
            state_d    = S_WR_WAIT;
          end else begin
            beat_d  = BEAT_W'(1);
            state_d = S_WR_RECV;
          end
        end
      end
      S_RD_WAIT: begin
        if (cmd == C2_READ_LINE || cmd == C2_WRITE_LINE || cmd == C2_RESPONSE) begin
          perr_d = 1'b1;
        end
        if (cnt_q == '0) begin
          beat_d  = '0;
          state_d = S_RD_SEND;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_RD_SEND: begin
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          beat_d    = '0;
          n_reads_d = n_reads_q + 32'd1;
          state_d   = S_IDLE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      S_WR_RECV: begin
        if (cmd != C2_WRITE_LINE) begin
          perr_d = 1'b1;
        end
        wbuf_d = wline;
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          commit_en = 1'b1;
          beat_d    = '0;
          cnt_d     = 32'(WR_LATENCY - BEATS);
          state_d   = S_WR_WAIT;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      S_WR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_WR_RESP;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_WR_RESP: begin
        n_writes_d = n_writes_q + 32'd1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus drive: response + beat data while sending a line, response alone for the write ack
  always_comb begin
    drive_cmd  = 1'b0;
    drive_data = 1'b0;
    rd_line    = mem_q[line_q];
    beat_out   = rd_line[beat_q*BUS_W +: BUS_W];
    unique case (state_q)
      S_RD_SEND: begin
        drive_cmd  = 1'b1;
        drive_data = 1'b1;
      end
      S_WR_RESP: drive_cmd = 1'b1;
      default: ;
    endcase
  end

  assign cmd       = drive_cmd  ? C2_RESPONSE : 'z;
  assign data      = drive_data ? beat_out    : 'z;
  assign n_reads   = n_reads_q;
  assign n_writes  = n_writes_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_mem_line_model.sv
// Bench for mem_line_model: directed scenarios plus random traffic against a line-array model.
// Instance A: 64 x 16-byte lines, 2-byte beats, zero init. Instance B: 16 x 32-byte lines,
// 4-byte beats, LFSR init (contents learned on first read, then held to).
module tb_mem_line_model;

  localparam logic [1:0] C2_NOP   = 2'd0;
  localparam logic [1:0] C2_READ  = 2'd1;
  localparam logic [1:0] C2_WRITE = 2'd2;
  localparam logic [1:0] C2_RESP  = 2'd3;
  localparam int RL_A = 5;
  localparam int WL_A = 12;
  localparam int RL_B = 3;
  localparam int WL_B = 11;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_dump;
  logic [13:0] addr_a, addr_b;
  wire  [15:0] data_a;
  wire  [1:0]  cmd_a;
  wire  [31:0] data_b;
  wire  [1:0]  cmd_b;
  logic [31:0] n_reads_a, n_writes_a, n_reads_b, n_writes_b;
  logic        perr_a, perr_b;

  logic        men_a, men_b;
  logic [1:0]  mc_a, mc_b;
  logic [15:0] md_a;
  logic [31:0] md_b;

  assign cmd_a  = men_a ? mc_a : 'z;
  assign data_a = men_a ? md_a : 'z;
  assign cmd_b  = men_b ? mc_b : 'z;
  assign data_b = men_b ? md_b : 'z;

  int errors = 0;
  int checks = 0;

  logic [255:0] mem_m [2][64];
  bit           known [2][64];
  int unsigned  rd_m [2];
  int unsigned  wr_m [2];
  bit           perr_m [2];

  logic [255:0] got, got1, rline;
  logic [13:0]  ra;

  always #5 clk = ~clk;

  mem_line_model #(
    .MEM_LINES(64), .LINE_BYTES(16), .BUS_BYTES(2), .ADDR_W(14),
    .RD_LATENCY(RL_A), .WR_LATENCY(WL_A), .INIT_MODE(0), .SEED(32'd225)
  ) dut_a (
    .clk(clk), .reset(reset), .m_dump(m_dump), .addr(addr_a), .data(data_a), .cmd(cmd_a),
    .n_reads(n_reads_a), .n_writes(n_writes_a), .proto_err(perr_a)
  );

  mem_line_model #(
    .MEM_LINES(16), .LINE_BYTES(32), .BUS_BYTES(4), .ADDR_W(14),
    .RD_LATENCY(RL_B), .WR_LATENCY(WL_B), .INIT_MODE(1), .SEED(32'd1)
  ) dut_b (
    .clk(clk), .reset(reset), .m_dump(m_dump), .addr(addr_b), .data(data_b), .cmd(cmd_b),
    .n_reads(n_reads_b), .n_writes(n_writes_b), .proto_err(perr_b)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      mem_m[0][i] = '0;
      known[0][i] = 1'b1;
      mem_m[1][i] = '0;
      known[1][i] = 1'b0;
    end
    for (int b = 0; b < 2; b++) begin
      rd_m[b]   = 0;
      wr_m[b]   = 0;
      perr_m[b] = 1'b0;
    end
  endfunction

  function automatic logic [1:0] cmd_of(input bit b);
    return b ? cmd_b : cmd_a;
  endfunction

  function automatic logic [31:0] data_of(input bit b);
    return b ? data_b : {16'h0, data_a};
  endfunction

  function automatic logic [31:0] nr(input bit b);
    return b ? n_reads_b : n_reads_a;
  endfunction

  function automatic logic [31:0] nw(input bit b);
    return b ? n_writes_b : n_writes_a;
  endfunction

  function automatic logic pe(input bit b);
    return b ? perr_b : perr_a;
  endfunction

  task automatic drive(input bit b, input logic en, input logic [1:0] c, input logic [13:0] a,
                       input logic [31:0] d);
    if (b) begin
      men_b = en; mc_b = c; addr_b = a; md_b = d;
    end else begin
      men_a = en; mc_a = c; addr_a = a; md_a = d[15:0];
    end
  endtask

  task automatic wr(input bit b, input logic [13:0] a, input logic [255:0] line_in);
    logic [255:0] line;
    int n, idx, bw;
    bit found;
    line = line_in;
    if (!b) line[255:128] = '0;
    bw = b ? 32 : 16;
    idx = int'(a) % (b ? 16 : 64);
    n = 0;
    found = 1'b0;
    @(negedge clk); drive(b, 1'b1, C2_WRITE, a, 32'(line));
    @(posedge clk);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk); drive(b, 1'b1, C2_WRITE, a, 32'(line >> (k * bw)));
      @(posedge clk); n++;
    end
    @(negedge clk); drive(b, 1'b0, C2_NOP, a, '0);
    while (!found && n < 200) begin
      @(posedge clk); #1; n++;
      if (cmd_of(b) === C2_RESP) found = 1'b1;
    end
    chk("wr_latency", 256'(n), 256'(b ? WL_B : WL_A));
    @(posedge clk); #1;
    chk("wr_release", 256'(cmd_of(b) === C2_RESP), 256'(0));
    mem_m[b][idx] = line;
    known[b][idx] = 1'b1;
    wr_m[b]++;
    chk("n_writes", 256'(nw(b)), 256'(wr_m[b]));
    chk("proto_err_wr", 256'(pe(b)), 256'(perr_m[b]));
  endtask

  task automatic rd(input bit b, input logic [13:0] a, input bit inject, input int abort_beat,
                    output logic [255:0] line);
    int n, idx, bw;
    bit found;
    bw = b ? 32 : 16;
    idx = int'(a) % (b ? 16 : 64);
    n = 0;
    found = 1'b0;
    line = '0;
    @(negedge clk); drive(b, 1'b1, C2_READ, a, '0);
    @(posedge clk);
    @(negedge clk); drive(b, 1'b0, C2_NOP, a, '0);
    while (!found && n < 200) begin
      @(posedge clk); #1; n++;
      if (cmd_of(b) === C2_RESP) found = 1'b1;
      else if (inject && n == 1) drive(b, 1'b1, C2_READ, a, '0);
      else if (inject && n == 2) drive(b, 1'b0, C2_NOP, a, '0);
    end
    if (inject) perr_m[b] = 1'b1;
    chk("rd_latency", 256'(n), 256'(b ? RL_B : RL_A));
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk("rd_beat_cmd", 256'(cmd_of(b)), 256'(C2_RESP));
      line = line | (256'(data_of(b)) << (k * bw));
      if (k == abort_beat) begin
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_release", 256'(cmd_of(b) === C2_RESP), 256'(0));
        @(negedge clk); reset = 1'b0;
        model_reset();
        chk("abort_n_reads", 256'(nr(b)), 256'(0));
        chk("abort_proto_err", 256'(pe(b)), 256'(0));
        return;
      end
    end
    @(posedge clk); #1;
    chk("rd_release", 256'(cmd_of(b) === C2_RESP), 256'(0));
    rd_m[b]++;
    if (known[b][idx]) begin
      chk("rd_data", line, mem_m[b][idx]);
    end else begin
      mem_m[b][idx] = line;
      known[b][idx] = 1'b1;
    end
    chk("n_reads", 256'(nr(b)), 256'(rd_m[b]));
    chk("proto_err_rd", 256'(pe(b)), 256'(perr_m[b]));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    m_dump = 1'b0;
    drive(1'b0, 1'b0, C2_NOP, '0, '0);
    drive(1'b1, 1'b0, C2_NOP, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    model_reset();

    // reset state of both instances
    chk("rst_n_reads_a", 256'(n_reads_a), 256'(0));
    chk("rst_n_writes_a", 256'(n_writes_a), 256'(0));
    chk("rst_perr_a", 256'(perr_a), 256'(0));
    chk("rst_release_a", 256'(cmd_a === C2_RESP), 256'(0));
    chk("rst_n_reads_b", 256'(n_reads_b), 256'(0));
    chk("rst_perr_b", 256'(perr_b), 256'(0));

    // zero-initialised line 0
    rd(1'b0, 14'd0, 1'b0, -1, got);

    // DEADBEEF line to line 5 and back
    wr(1'b0, 14'd5, {8{32'hDEAD_BEEF}});
    rd(1'b0, 14'd5, 1'b0, -1, got);

    // address wrap: MEM_LINES+5 aliases line 5, upper bits ignored
    wr(1'b0, 14'd69, {8{32'h1234_5678}} ^ 256'h00FF_00FF_AA55);
    rd(1'b0, 14'd5, 1'b0, -1, got);
    wr(1'b0, 14'h3FC7, {8{32'hC0DE_F00D}});
    rd(1'b0, 14'd7, 1'b0, -1, got);

    // protocol error during RD_WAIT, sticky across later transactions
    rd(1'b0, 14'd9, 1'b1, -1, got);
    rd(1'b0, 14'd5, 1'b0, -1, got);

    // reset during beat 2 of a read, then memory back to zeros
    rd(1'b0, 14'd5, 1'b0, 2, got);
    rd(1'b0, 14'd5, 1'b0, -1, got);

    // random traffic on instance A
    repeat (24) begin
      ra = 14'($urandom);
      m_dump = 1'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        for (int w = 0; w < 8; w++) rline[w*32 +: 32] = $urandom;
        wr(1'b0, ra, rline);
      end else begin
        rd(1'b0, ra, 1'b0, -1, got);
      end
    end
    m_dump = 1'b0;

    // instance B: LFSR contents, back-to-back reads of line 3 agree
    rd(1'b1, 14'd3, 1'b0, -1, got1);
    chk("b_init_nonzero", 256'(got1 === '0), 256'(0));
    rd(1'b1, 14'd3, 1'b0, -1, got);
    wr(1'b1, 14'd19, {8{32'hDEAD_BEEF}} ^ 256'h1);
    rd(1'b1, 14'd3, 1'b0, -1, got);
    repeat (8) begin
      ra = 14'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        for (int w = 0; w < 8; w++) rline[w*32 +: 32] = $urandom;
        wr(1'b1, ra, rline);
      end else begin
        rd(1'b1, ra, 1'b0, -1, got);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
